// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: controller FSM state encoding, default bus widths and index-width helper.
package gpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} mem_state_t;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lsu_mem_controller_if.sv
// lsu_mem_controller_if: per-thread LSU request/response lanes plus the single shared memory channel.
interface lsu_mem_controller_if import gpu_mem_pkg::*; #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic [NUM_THREADS-1:0] lsu_read_valid;
  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] lsu_read_addr;
  logic [NUM_THREADS-1:0] lsu_write_valid;
  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] lsu_write_addr;
  logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_write_data;
  logic [NUM_THREADS-1:0] lsu_ready;
  logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_read_data;
  logic mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_addr;
  logic mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_addr;
  logic [DATA_BITS-1:0] mem_write_data;
  logic mem_write_ready;
  modport master (
    input lsu_read_valid, lsu_read_addr, lsu_write_valid, lsu_write_addr, lsu_write_data,
    input mem_read_ready, mem_read_data, mem_write_ready,
    output lsu_ready, lsu_read_data,
    output mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );
  modport slave (
    output lsu_read_valid, lsu_read_addr, lsu_write_valid, lsu_write_addr, lsu_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input lsu_ready, lsu_read_data,
    input mem_read_valid, mem_read_addr, mem_write_valid, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: grants the first requester found searching upward from ptr (wrapping);
// with ptr held at 0 this is plain lowest-index priority.
module lsu_arbiter import gpu_mem_pkg::*; #(
  parameter int NUM_THREADS = 4,
  parameter int IDX_W = idx_bits(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_THREADS-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);
  assign any = |req;
  // Walk from the farthest offset down so the nearest requester to ptr is written last.
  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = NUM_THREADS - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % NUM_THREADS);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/lsu_mem_controller.sv
// lsu_mem_controller: serves one LSU thread at a time on a single memory read/write channel.
// Define LSU_MEM_RR_ARB_EN for round-robin grant; default build uses fixed lowest-index priority.
module lsu_mem_controller import gpu_mem_pkg::*; #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input logic clk,
  input logic reset,
  lsu_mem_controller_if.master bus
);
  localparam int IDX_W = idx_bits(NUM_THREADS);
  mem_state_t state, state_d;
  logic [IDX_W-1:0] id, id_d, ptr, gidx;
  logic [NUM_THREADS-1:0] ready, ready_d, req, grant;
  logic [NUM_THREADS-1:0][DATA_BITS-1:0] rdata, rdata_d;
  logic rd_v, rd_v_d, wr_v, wr_v_d, any, done, is_read;
  logic [ADDR_BITS-1:0] rd_a, rd_a_d, wr_a, wr_a_d;
  logic [DATA_BITS-1:0] wr_d, wr_d_d;
  assign req = (bus.lsu_read_valid | bus.lsu_write_valid) & ~ready;
  assign is_read = |(bus.lsu_read_valid & grant);
  assign done = !bus.lsu_read_valid[id] && !bus.lsu_write_valid[id];
  lsu_arbiter #(.NUM_THREADS(NUM_THREADS), .IDX_W(IDX_W)) u_arb (
    .req(req), .ptr(ptr), .grant(grant), .idx(gidx), .any(any)
  );
`ifdef LSU_MEM_RR_ARB_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (state == RELAY && done) ptr <= (id == IDX_W'(NUM_THREADS - 1)) ? '0 : id + 1'b1;
`else
  assign ptr = '0;
`endif
  always_comb begin
    state_d = state;
    id_d = id;
    ready_d = ready;
    rdata_d = rdata;
    rd_v_d = rd_v;
    rd_a_d = rd_a;
    wr_v_d = wr_v;
    wr_a_d = wr_a;
    wr_d_d = wr_d;
    case (state)
      IDLE: if (any) begin
        id_d = gidx;
        state_d = is_read ? READ_WAIT : WRITE_WAIT;
        rd_v_d = is_read;
        wr_v_d = !is_read;
        rd_a_d = is_read ? bus.lsu_read_addr[gidx] : rd_a;
        wr_a_d = is_read ? wr_a : bus.lsu_write_addr[gidx];
        wr_d_d = is_read ? wr_d : bus.lsu_write_data[gidx];
      end
      READ_WAIT: if (bus.mem_read_ready) begin
        rdata_d[id] = bus.mem_read_data;
        ready_d[id] = 1'b1;
        rd_v_d = 1'b0;
        state_d = RELAY;
      end
      WRITE_WAIT: if (bus.mem_write_ready) begin
        ready_d[id] = 1'b1;
        wr_v_d = 1'b0;
        state_d = RELAY;
      end
      RELAY: if (done) begin
        ready_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      id <= '0;
      ready <= '0;
      rdata <= '0;
      rd_v <= 1'b0;
      rd_a <= '0;
      wr_v <= 1'b0;
      wr_a <= '0;
      wr_d <= '0;
    end else begin
      state <= state_d;
      id <= id_d;
      ready <= ready_d;
      rdata <= rdata_d;
      rd_v <= rd_v_d;
      rd_a <= rd_a_d;
      wr_v <= wr_v_d;
      wr_a <= wr_a_d;
      wr_d <= wr_d_d;
    end
  assign bus.lsu_ready = ready;
  assign bus.lsu_read_data = rdata;
  assign bus.mem_read_valid = rd_v;
  assign bus.mem_read_addr = rd_a;
  assign bus.mem_write_valid = wr_v;
  assign bus.mem_write_addr = wr_a;
  assign bus.mem_write_data = wr_d;
endmodule

// File: tb/tb_lsu_mem_controller.sv
// tb_lsu_mem_controller: directed scenarios for the LSU memory controller; honours LSU_MEM_RR_ARB_EN.
module tb_lsu_mem_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  lsu_mem_controller_if #(.NUM_THREADS(4), .ADDR_BITS(8), .DATA_BITS(8)) bus ();
  lsu_mem_controller #(.NUM_THREADS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic clear_inputs();
    bus.lsu_read_valid = '0;
    bus.lsu_read_addr = '0;
    bus.lsu_write_valid = '0;
    bus.lsu_write_addr = '0;
    bus.lsu_write_data = '0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data = '0;
    bus.mem_write_ready = 1'b0;
  endtask
  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic complete_read(input int t, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (bus.mem_read_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== a) begin
      errors++;
      $display("FAIL grant_t%0d: mem_read_valid=%b addr=%h, expected 1 addr=%h", t, bus.mem_read_valid, bus.mem_read_addr, a);
    end
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data = d;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    vectors++;
    if (bus.lsu_ready !== 4'(1 << t) || bus.lsu_read_data[t] !== d || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL relay_t%0d: lsu_ready=%b data=%h mrv=%b, expected %b data=%h mrv=0", t, bus.lsu_ready, bus.lsu_read_data[t], bus.mem_read_valid, 4'(1 << t), d);
    end
    bus.lsu_read_valid[t] = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0) begin
      errors++;
      $display("FAIL release_t%0d: lsu_ready=%b, expected 0000", t, bus.lsu_ready);
    end
  endtask
  task automatic test_reset();
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.lsu_ready, bus.mem_read_valid, bus.mem_write_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids: ready=%b mrv=%b mwv=%b, expected all 0", bus.lsu_ready, bus.mem_read_valid, bus.mem_write_valid);
    end
    vectors++;
    if (bus.lsu_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: %h, expected 0", bus.lsu_read_data);
    end
    vectors++;
    if ({bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: %h %h %h, expected 0", bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b mrv=%b, expected 0000/0", bus.lsu_ready, bus.mem_read_valid);
    end
  endtask
  task automatic test_single_read();
    bus.lsu_read_addr[2] = 8'h10;
    bus.lsu_read_valid[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 8'h10 || bus.lsu_ready !== 4'b0) begin
      errors++;
      $display("FAIL read_issue: mrv=%b addr=%h ready=%b, expected 1/10/0000", bus.mem_read_valid, bus.mem_read_addr, bus.lsu_ready);
    end
    @(negedge clk);
    vectors++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 8'h10 || bus.lsu_ready !== 4'b0) begin
      errors++;
      $display("FAIL read_hold: mrv=%b addr=%h ready=%b, expected 1/10/0000", bus.mem_read_valid, bus.mem_read_addr, bus.lsu_ready);
    end
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data = 8'hAB;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data = 8'h00;
    vectors++;
    if (bus.lsu_ready !== 4'b0100 || bus.lsu_read_data[2] !== 8'hAB || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done: ready=%b data=%h mrv=%b, expected 0100/ab/0", bus.lsu_ready, bus.lsu_read_data[2], bus.mem_read_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0100) begin
      errors++;
      $display("FAIL read_relay_hold: ready=%b, expected 0100", bus.lsu_ready);
    end
    bus.lsu_read_valid[2] = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0 || bus.lsu_read_data[2] !== 8'hAB) begin
      errors++;
      $display("FAIL read_release: ready=%b data=%h, expected 0000/ab", bus.lsu_ready, bus.lsu_read_data[2]);
    end
  endtask
  task automatic test_single_write();
    bus.lsu_write_addr[0] = 8'h20;
    bus.lsu_write_data[0] = 8'h05;
    bus.lsu_write_valid[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_write_valid !== 1'b1 || bus.mem_write_addr !== 8'h20 || bus.mem_write_data !== 8'h05 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_issue: mwv=%b addr=%h data=%h mrv=%b, expected 1/20/05/0", bus.mem_write_valid, bus.mem_write_addr, bus.mem_write_data, bus.mem_read_valid);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.mem_write_valid !== 1'b1 || bus.mem_write_addr !== 8'h20 || bus.mem_write_data !== 8'h05 || bus.lsu_ready !== 4'b0) begin
      errors++;
      $display("FAIL write_hold: mwv=%b addr=%h data=%h ready=%b, expected 1/20/05/0000", bus.mem_write_valid, bus.mem_write_addr, bus.mem_write_data, bus.lsu_ready);
    end
    bus.mem_write_ready = 1'b1;
    @(negedge clk);
    bus.mem_write_ready = 1'b0;
    vectors++;
    if (bus.lsu_ready !== 4'b0001 || bus.mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_done: ready=%b mwv=%b, expected 0001/0", bus.lsu_ready, bus.mem_write_valid);
    end
    bus.lsu_write_valid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0) begin
      errors++;
      $display("FAIL write_release: ready=%b, expected 0000", bus.lsu_ready);
    end
  endtask
  task automatic test_burst();
    int first;
    do_reset();
    for (int i = 0; i < 4; i++) bus.lsu_read_addr[i] = 8'h40 + 8'(i);
    bus.lsu_read_valid = 4'hF;
    for (int i = 0; i < 4; i++) complete_read(i, 8'h40 + 8'(i), 8'hA0 + 8'(i));
    bus.lsu_read_valid = 4'hF;
    for (int i = 0; i < 4; i++) complete_read(i, 8'h40 + 8'(i), 8'hB0 + 8'(i));
    bus.lsu_read_valid = 4'b0010;
    complete_read(1, 8'h41, 8'hC1);
`ifdef LSU_MEM_RR_ARB_EN
    first = 2;
`else
    first = 0;
`endif
    bus.lsu_read_valid = 4'hF;
    for (int i = 0; i < 4; i++) complete_read((first + i) % 4, 8'h40 + 8'((first + i) % 4), 8'hD0 + 8'((first + i) % 4));
  endtask
  task automatic test_read_write_same();
    bus.lsu_read_addr[1] = 8'h31;
    bus.lsu_write_addr[1] = 8'h32;
    bus.lsu_write_data[1] = 8'h77;
    bus.lsu_read_valid[1] = 1'b1;
    bus.lsu_write_valid[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_write_valid !== 1'b0 || bus.mem_read_addr !== 8'h31) begin
      errors++;
      $display("FAIL rw_read_first: mrv=%b mwv=%b addr=%h, expected 1/0/31", bus.mem_read_valid, bus.mem_write_valid, bus.mem_read_addr);
    end
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data = 8'h99;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    vectors++;
    if (bus.lsu_ready !== 4'b0010 || bus.lsu_read_data[1] !== 8'h99) begin
      errors++;
      $display("FAIL rw_read_done: ready=%b data=%h, expected 0010/99", bus.lsu_ready, bus.lsu_read_data[1]);
    end
    bus.lsu_read_valid[1] = 1'b0;
    bus.lsu_write_valid[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0 || bus.mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_release: ready=%b mwv=%b, expected 0000/0", bus.lsu_ready, bus.mem_write_valid);
    end
    bus.lsu_write_valid[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_write_valid !== 1'b1 || bus.mem_write_addr !== 8'h32 || bus.mem_write_data !== 8'h77 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_write_next: mwv=%b addr=%h data=%h mrv=%b, expected 1/32/77/0", bus.mem_write_valid, bus.mem_write_addr, bus.mem_write_data, bus.mem_read_valid);
    end
    bus.mem_write_ready = 1'b1;
    @(negedge clk);
    bus.mem_write_ready = 1'b0;
    vectors++;
    if (bus.lsu_ready !== 4'b0010 || bus.mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_write_done: ready=%b mwv=%b, expected 0010/0", bus.lsu_ready, bus.mem_write_valid);
    end
    bus.lsu_write_valid[1] = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_midflight();
    bus.lsu_read_addr[2] = 8'h55;
    bus.lsu_read_valid[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_addr !== 8'h55) begin
      errors++;
      $display("FAIL midflight_issue: mrv=%b addr=%h, expected 1/55", bus.mem_read_valid, bus.mem_read_addr);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.mem_read_valid !== 1'b0 || bus.mem_read_addr !== 8'h0 || bus.lsu_ready !== 4'b0 || bus.lsu_read_data !== 32'h0) begin
      errors++;
      $display("FAIL midflight_async_clear: mrv=%b addr=%h ready=%b rdata=%h, expected all 0", bus.mem_read_valid, bus.mem_read_addr, bus.lsu_ready, bus.lsu_read_data);
    end
    bus.lsu_read_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    bus.lsu_read_addr[3] = 8'h66;
    bus.lsu_read_valid[3] = 1'b1;
    complete_read(3, 8'h66, 8'h3C);
  endtask
  task automatic test_spurious_ready();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data = 8'hEE;
    bus.mem_write_ready = 1'b1;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    vectors++;
    if (bus.lsu_ready !== 4'b0 || bus.lsu_read_data !== 32'h3C00_0000 || bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ready: ready=%b rdata=%h mrv=%b mwv=%b, expected 0000/3c000000/0/0", bus.lsu_ready, bus.lsu_read_data, bus.mem_read_valid, bus.mem_write_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.lsu_ready !== 4'b0 || bus.lsu_read_data !== 32'h3C00_0000) begin
      errors++;
      $display("FAIL spurious_after: ready=%b rdata=%h, expected 0000/3c000000", bus.lsu_ready, bus.lsu_read_data);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_burst();
    test_read_write_same();
    test_reset_midflight();
    test_spurious_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
